game_ctrl: RTL
==============

// Module: game_ctrl
// PURPOSE
//  Top-level sequencer upstream of the datapath. Owns the state-register bank (state, board, location, rotation, piece) that the datapath reads.
//  Turns player buttons and a gravity timer into single-cycle MOVE requests. Latches the datapath results and walks GEN/MOVE/LAND/CLEAR/NEWBOARD/GAMEOVER.
// PARAMETERS
//  DROP_TICKS  4_000_000  clka cycles between gravity steps (>=2)
//  DROP_W      23         gravity counter width; must hold DROP_TICKS-1
// PORTS
//  clka            in   1   system clock, all flops rising edge
//  restart_n       in   1   asynchronous active-low reset
//  start           in   1   level; rising edge leaves GAMEOVER
//  btn_left        in   1   raw level, synchronised externally
//  btn_right       in   1   raw level
//  btn_rotate      in   1   raw level
//  touched         in   1   dp: piece landed during this MOVE cycle
//  error_in        in   1   dp: overflow on redraw (game lost)
//  board_in        in   32  dp board_out
//  location_in     in   5   dp location_out
//  rotation_in     in   2   dp rotation_out
//  piece_in        in   2   dp curr_piece_out
//  state           out  3   GEN=0 MOVE=1 LAND=2 CLEAR=3 NEWBOARD=4 GAMEOVER=5 WAIT=6
//  move            out  2   0=drop 1=left 2=right 3=rotate; valid only when state==MOVE
//  board           out  32  registered board, to dp board_in
//  location        out  5   registered, to dp location_in
//  rotation        out  2   registered, to dp rotation_in
//  piece           out  2   registered, to dp curr_piece_in
//  lines           out  8   count of CLEAR cycles that changed the board; saturates at 255
// BEHAVIOUR
//  Reset values: state=NEWBOARD, move=0, board=0, location=0, rotation=0, piece=0, lines=0, gravity count=0, pending flags=0.
//  Button handling: register each btn; a 0->1 edge sets a one-deep pending flag. Further edges while the flag is set are dropped.
//  Gravity: the counter increments only in WAIT. On reaching DROP_TICKS-1 it raises tick and wraps to 0. Elsewhere it holds.
//  NEWBOARD (1 cycle): board<=0 -> GEN.
//  GEN (1 cycle): piece<=piece_in; location<=(piece_in<2)?5'd1:5'd5; rotation<=0; board<=board_in -> WAIT.
//  WAIT: priority tick > rotate > left > right.
//   - Any request present -> MOVE next cycle, with move driven from the state register (registered, no comb path from buttons).
//   - The served pending flag clears as MOVE is entered. If tick and a button coincide, the button stays pending for a later MOVE.
//  MOVE (exactly 1 cycle): location<=location_in; rotation<=rotation_in; board<=board_in.
//   - touched=1 -> LAND; otherwise -> WAIT.
//  LAND (1 cycle): registers hold; all pending flags clear -> CLEAR.
//  CLEAR (1 cycle): board<=board_in; lines+=1 (saturating) if board_in!=board.
//   - error_in=1 -> GAMEOVER; otherwise -> GEN.
//  GAMEOVER: board<=32'hFFFF_FFFF; buttons ignored; start rising edge -> NEWBOARD.
//  Latency: button edge to MOVE = 2 cycles (edge reg + pending). MOVE result is visible on outputs 1 cycle after MOVE.
//  Async reset asserted in any state returns all outputs to reset values immediately. Deassertion resumes at NEWBOARD.
//  Unused encoding 7 -> NEWBOARD next cycle.
// CONFIGURATION
//  GAME_CTRL_PAUSE_EN defined: adds input pause (1 bit).
//   - While pause=1 and state==WAIT: gravity counter holds, button edges are ignored, and no MOVE is issued.
//   - Other states finish normally.
//  Undefined: no pause port; behaviour as above.
// TESTING
//  1 Reset low mid-MOVE, then release -> state=4 at once, board=0, lines=0. Next cycle state=0 (GEN).
//  2 DROP_TICKS=4, no buttons, touched=0 -> MOVE with move=0 every 5th cycle (4 WAIT + 1 MOVE).
//  3 btn_left and tick in the same WAIT cycle -> MOVE move=0, WAIT, MOVE move=1. Second btn_left edge while pending -> one MOVE only.
//  4 GEN with piece_in=2 -> location=5, rotation=0. MOVE with touched=1 -> LAND, CLEAR, GEN sequence.
//  5 CLEAR with board_in!=board 300 times -> lines saturates at 255.
//  6 CLEAR with error_in=1 -> GAMEOVER, board=FFFFFFFF. Buttons give no MOVE. Start edge -> NEWBOARD -> GEN.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: top-level sequencer for the falling-block game.
// Owns the state register bank (state, board, location, rotation, piece) read by the datapath.
// Button edges and a gravity timer become single-cycle MOVE requests.
// Datapath results are latched as the FSM walks GEN/WAIT/MOVE/LAND/CLEAR/NEWBOARD/GAMEOVER.
// Optional feature: define GAME_CTRL_PAUSE_EN to add a 'pause' input that freezes WAIT.
module game_ctrl #(
    parameter int unsigned DROP_TICKS = 4_000_000,
    parameter int unsigned DROP_W     = 23
) (
    input  logic        clka,
    input  logic        restart_n,
`ifdef GAME_CTRL_PAUSE_EN
    input  logic        pause,
`endif
    input  logic        start,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_rotate,
    input  logic        touched,
    input  logic        error_in,
    input  logic [31:0] board_in,
    input  logic [4:0]  location_in,
    input  logic [1:0]  rotation_in,
    input  logic [1:0]  piece_in,
    output logic [2:0]  state,
    output logic [1:0]  move,
    output logic [31:0] board,
    output logic [4:0]  location,
    output logic [1:0]  rotation,
    output logic [1:0]  piece,
    output logic [7:0]  lines
);

    typedef enum logic [2:0] {
        ST_GEN      = 3'd0,
        ST_MOVE     = 3'd1,
        ST_LAND     = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_NEWBOARD = 3'd4,
        ST_GAMEOVER = 3'd5,
        ST_WAIT     = 3'd6
    } state_e;

    localparam logic [1:0] MV_DROP   = 2'd0;
    localparam logic [1:0] MV_LEFT   = 2'd1;
    localparam logic [1:0] MV_RIGHT  = 2'd2;
    localparam logic [1:0] MV_ROTATE = 2'd3;

    // Pending / button vector bit positions
    localparam int unsigned P_LEFT  = 0;
    localparam int unsigned P_RIGHT = 1;
    localparam int unsigned P_ROT   = 2;

    localparam logic [DROP_W-1:0] CNT_LAST = DROP_W'(DROP_TICKS - 1);

    state_e            state_q, state_d;
    logic [1:0]        move_q, move_d;
    logic [31:0]       board_q, board_d;
    logic [4:0]        loc_q, loc_d;
    logic [1:0]        rot_q, rot_d;
    logic [1:0]        piece_q, piece_d;
    logic [7:0]        lines_q, lines_d;
    logic [DROP_W-1:0] cnt_q, cnt_d;
    logic [2:0]        pend_q, pend_d;
    logic [2:0]        btn_q;
    logic              start_q;

    logic [2:0]        btn_c;
    logic [2:0]        edge_c;
    logic              start_edge_c;
    logic              paused_c;
    logic              tick_c;

    assign btn_c        = {btn_rotate, btn_right, btn_left};
    assign edge_c       = btn_c & ~btn_q;
    assign start_edge_c = start & ~start_q;

`ifdef GAME_CTRL_PAUSE_EN
    assign paused_c = pause && (state_q == ST_WAIT);
`else
    assign paused_c = 1'b0;
`endif

    // State register bank, edge detectors, gravity counter and pending flags
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q <= ST_NEWBOARD;
            move_q  <= MV_DROP;
            board_q <= '0;
            loc_q   <= '0;
            rot_q   <= '0;
            piece_q <= '0;
            lines_q <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            btn_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            move_q  <= move_d;
            board_q <= board_d;
            loc_q   <= loc_d;
            rot_q   <= rot_d;
            piece_q <= piece_d;
            lines_q <= lines_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            btn_q   <= btn_c;
            start_q <= start;
        end
    end

    // Next-state and register-bank update logic
    always_comb begin
        state_d = state_q;
        move_d  = move_q;
        board_d = board_q;
        loc_d   = loc_q;
        rot_d   = rot_q;
        piece_d = piece_q;
        lines_d = lines_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        tick_c  = 1'b0;

        // Gravity only advances while waiting for a request
        if ((state_q == ST_WAIT) && !paused_c) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                tick_c = 1'b1;
            end else begin
                cnt_d = cnt_q + DROP_W'(1);
            end
        end

        // One-deep pending flags; an edge on an already-set flag is dropped
        if ((state_q != ST_GAMEOVER) && !paused_c) begin
            pend_d = pend_q | edge_c;
        end

        case (state_q)
            ST_NEWBOARD: begin
                board_d = '0;
                state_d = ST_GEN;
            end
            ST_GEN: begin
                piece_d = piece_in;
                loc_d   = (piece_in < 2'd2) ? 5'd1 : 5'd5;
                rot_d   = 2'd0;
                board_d = board_in;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!paused_c) begin
                    if (tick_c) begin
                        state_d = ST_MOVE;
                        move_d  = MV_DROP;
                    end else if (pend_q[P_ROT]) begin
                        state_d        = ST_MOVE;
                        move_d         = MV_ROTATE;
                        pend_d[P_ROT]  = 1'b0;
                    end else if (pend_q[P_LEFT]) begin
                        state_d        = ST_MOVE;
                        move_d         = MV_LEFT;
                        pend_d[P_LEFT] = 1'b0;
                    end else if (pend_q[P_RIGHT]) begin
                        state_d         = ST_MOVE;
                        move_d          = MV_RIGHT;
                        pend_d[P_RIGHT] = 1'b0;
                    end
                end
            end
            ST_MOVE: begin
                loc_d   = location_in;
                rot_d   = rotation_in;
                board_d = board_in;
                state_d = touched ? ST_LAND : ST_WAIT;
            end
            ST_LAND: begin
                pend_d  = '0;
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                board_d = board_in;
                if ((board_in != board_q) && (lines_q != 8'hFF)) begin
                    lines_d = lines_q + 8'd1;
                end
                state_d = error_in ? ST_GAMEOVER : ST_GEN;
            end
            ST_GAMEOVER: begin
                board_d = 32'hFFFF_FFFF;
                if (start_edge_c) begin
                    state_d = ST_NEWBOARD;
                end
            end
            default: begin
                state_d = ST_NEWBOARD;
            end
        endcase
    end

    assign state    = state_q;
    assign move     = move_q;
    assign board    = board_q;
    assign location = loc_q;
    assign rotation = rot_q;
    assign piece    = piece_q;
    assign lines    = lines_q;

endmodule
